// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Package : seg7_pkg
//  Purpose : Shared constants and types for the 4-digit 7-segment scan
//            driver: digit count, blank pattern, and the hex glyph table.
//  Contents: DIGITS, SEG_BLANK, HEX_TABLE, nibble_t, seg_code_t, hex_code()
//  Revision: 1.0  initial release
// ============================================================================
package seg7_pkg;

  localparam int DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_code_t;  // active-low {g,f,e,d,c,b,a}

  localparam seg_code_t SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n, listed from F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic seg_code_t hex_code(input nibble_t n);
    return HEX_TABLE[n];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Interface : seg7_scan_driver_if
//  Purpose   : Bundles the display-word input side and the anode/segment
//              output side of the scan driver.
//  Signals   : data_in[31:0], data_valid, half_sel, blank_lz  (to driver)
//              anode[3:0], seg[7:0]                            (from driver)
//  Modports  : master - word source / display observer
//              slave  - the scan driver itself
//  Revision  : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [31:0]       data_in;
  logic              data_valid;
  logic              half_sel;
  logic              blank_lz;
  logic [DIGITS-1:0] anode;
  logic [7:0]        seg;

  modport master (
    output data_in, data_valid, half_sel, blank_lz,
    input  anode, seg
  );

  modport slave (
    input  data_in, data_valid, half_sel, blank_lz,
    output anode, seg
  );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module  : hex_to_seg7
//  Purpose : Combinational hex nibble to active-low 7-segment glyph decoder.
//  Ports   : i_nib [3:0]  hex digit
//            o_seg [6:0]  active-low {g,f,e,d,c,b,a}
//  Revision: 1.0  initial release
// ============================================================================
module hex_to_seg7
  import seg7_pkg::*;
(
  input  nibble_t   i_nib,
  output seg_code_t o_seg
);

  assign o_seg = hex_code(i_nib);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module  : seg7_scan_driver
//  Purpose : Shows one 16-bit half of a snapshotted 32-bit word as hex on a
//            4-digit common-anode display. Digits are time-multiplexed with
//            a prescaler; each slot begins with all anodes off to suppress
//            ghosting. Optional leading-zero suppression.
//  Ports   : clk    system clock
//            reset  synchronous, active-high
//            bus    seg7_scan_driver_if.slave (data_in, data_valid,
//                   half_sel, blank_lz in; anode, seg out, active-low)
//  Params  : REFRESH_DIV   clk cycles per digit slot (>= 2)
//            BLANK_CYCLES  leading anode-off cycles per slot (< REFRESH_DIV)
//            CNT_W         prescaler width (must hold REFRESH_DIV-1)
//  Revision: 1.0  initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  seg7_scan_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] c_PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_BLANK_END  = CNT_W'(BLANK_CYCLES);

  logic [31:0]      r_snap;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  nibble_t          r_slot_nib;
  logic             r_slot_blank;
  logic             r_hold;        // keeps outputs dark on the first edge after reset
  logic [3:0]       r_anode;
  logic [7:0]       r_seg;

  logic             w_slot_end;
  logic [15:0]      w_half;
  logic [1:0]       w_next_idx;
  nibble_t          w_next_nib;
  logic             w_upper_zero;
  logic             w_next_blank;
  seg_code_t        w_code;
  logic             w_dp_n;
  logic [3:0]       w_anode;

  assign w_slot_end = (r_presc == c_PRESC_LAST);
  assign w_half     = bus.half_sel ? r_snap[31:16] : r_snap[15:0];
  assign w_next_idx = r_idx + 2'd1;

  // Content for the slot that starts after this edge: the digit selector
  // looks one position ahead because idx advances on the same edge.
  always_comb begin
    w_next_nib   = w_half[3:0];
    w_upper_zero = 1'b0;
    case (w_next_idx)
      2'd0: begin
        w_next_nib   = w_half[3:0];
        w_upper_zero = 1'b0;             // rightmost digit always shows
      end
      2'd1: begin
        w_next_nib   = w_half[7:4];
        w_upper_zero = (w_half[15:4] == 12'd0);
      end
      2'd2: begin
        w_next_nib   = w_half[11:8];
        w_upper_zero = (w_half[15:8] == 8'd0);
      end
      default: begin
        w_next_nib   = w_half[15:12];
        w_upper_zero = (w_half[15:12] == 4'd0);
      end
    endcase
  end

  assign w_next_blank = bus.blank_lz & w_upper_zero;

  hex_to_seg7 u_hex (
    .i_nib (r_slot_nib),
    .o_seg (w_code)
  );

  // Decimal point on the leftmost digit flags that the upper half is shown.
  assign w_dp_n  = ~((r_idx == 2'd3) & bus.half_sel);
  assign w_anode = ((r_presc < c_BLANK_END) || r_slot_blank) ? 4'hF
                                                             : ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap       <= 32'd0;
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_slot_nib   <= 4'd0;
      r_slot_blank <= 1'b0;
      r_hold       <= 1'b1;
      r_anode      <= 4'hF;
      r_seg        <= {1'b1, SEG_BLANK};
    end else begin
      if (bus.data_valid) begin
        r_snap <= bus.data_in;
      end

      if (w_slot_end) begin
        r_presc      <= '0;
        r_idx        <= w_next_idx;
        r_slot_nib   <= w_next_nib;
        r_slot_blank <= w_next_blank;
      end else begin
        r_presc      <= r_presc + CNT_W'(1);
      end

      r_hold <= 1'b0;
      if (r_hold) begin
        r_anode <= 4'hF;
        r_seg   <= {1'b1, SEG_BLANK};
      end else begin
        r_anode <= w_anode;
        r_seg   <= {w_dp_n, w_code};
      end
    end
  end

  assign bus.anode = r_anode;
  assign bus.seg   = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seg7_scan_driver
//  Purpose : Self-checking bench for seg7_scan_driver (REFRESH_DIV=4,
//            BLANK_CYCLES=1). Expected per-cycle anode/seg values are queued
//            with their edge number; a monitor compares on falling edges.
//  Revision: 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic reset;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .CNT_W        (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] sg;
    int         tid;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   multi_low = 0;
  bit   done      = 1'b0;

  localparam int R  = 12;    // last reset edge of the mid-scan reset
  localparam int NF = 1250;  // free-run slots

  task automatic push(input int c, input logic [3:0] an, input logic [7:0] sg, input int tid);
    exp_t e;
    e.cyc = c; e.an = an; e.sg = sg; e.tid = tid;
    q.push_back(e);
  endtask

  // Slot s after release edge r occupies edges r+1+4s .. r+4+4s; its first
  // edge is always dark, the remaining three light digit d unless blanked.
  task automatic push_slot(input int r, input int s, input int d,
                           input logic [7:0] sg, input bit blanked, input int tid);
    logic [3:0] lit;
    lit = ~(4'b0001 << d);
    push(r + 1 + 4*s, 4'hF, sg, tid);
    for (int p = 1; p < 4; p++) push(r + 1 + 4*s + p, blanked ? 4'hF : lit, sg, tid);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!done) begin
      if ($countones(~bus.anode) > 1) multi_low++;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL t%0d missed cyc=%0d", q[0].tid, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({bus.anode, bus.seg} !== {e.an, e.sg}) begin
          failures++;
          $display("FAIL t%0d cyc=%0d anode=%h seg=%h required anode=%h seg=%h",
                   e.tid, cyc, bus.anode, bus.seg, e.an, e.sg);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.data_in    = 32'd0;
    bus.data_valid = 1'b0;
    bus.half_sel   = 1'b0;
    bus.blank_lz   = 1'b0;

    // ---- test 1: reset values, short run, mid-scan reset, restart ----
    for (int c = 1; c <= 3; c++) push(c, 4'hF, 8'hFF, 1);
    push(4, 4'hF, 8'hFF, 1);
    for (int c = 5; c <= 7; c++) push(c, 4'hE, 8'hC0, 1);
    push(8, 4'hF, 8'hC0, 1);
    push(9, 4'hD, 8'hC0, 1);
    for (int c = 10; c <= 12; c++) push(c, 4'hF, 8'hFF, 1);
    push(R + 1, 4'hF, 8'hFF, 1);
    for (int p = 2; p <= 4; p++) push(R + p, 4'hE, 8'hC0, 1);

    // ---- test 2: 0x1234ABCD lower half ----
    push_slot(R, 1, 1, 8'hC6, 1'b0, 2);
    push_slot(R, 2, 2, 8'h83, 1'b0, 2);
    push_slot(R, 3, 3, 8'h88, 1'b0, 2);
    push_slot(R, 4, 0, 8'hA1, 1'b0, 2);
    // ---- test 3: upper half, dp on digit 3 ----
    push_slot(R, 5, 1, 8'hB0, 1'b0, 3);
    push_slot(R, 6, 2, 8'hA4, 1'b0, 3);
    push_slot(R, 7, 3, 8'h79, 1'b0, 3);
    push_slot(R, 8, 0, 8'h99, 1'b0, 3);
    // ---- test 4: leading-zero suppression ----
    push_slot(R, 9,  1, 8'hC0, 1'b1, 4);
    push_slot(R, 10, 2, 8'hC0, 1'b1, 4);
    push_slot(R, 11, 3, 8'hC0, 1'b1, 4);
    push_slot(R, 12, 0, 8'h92, 1'b0, 4);
    push_slot(R, 13, 1, 8'hC0, 1'b1, 4);
    push_slot(R, 14, 2, 8'hC0, 1'b1, 4);
    push_slot(R, 15, 3, 8'hC0, 1'b1, 4);
    push_slot(R, 16, 0, 8'hC0, 1'b0, 4);
    // ---- test 5: mid-slot strobe and slot-end strobe ----
    push_slot(R, 17, 1, 8'h8E, 1'b0, 5);
    push_slot(R, 18, 2, 8'hF9, 1'b0, 5);
    push_slot(R, 19, 3, 8'hF9, 1'b0, 5);
    push_slot(R, 20, 0, 8'hA4, 1'b0, 5);
    // ---- test 6: free run on 0x2222 ----
    for (int s = 21; s < 21 + NF; s++) push_slot(R, s, s % 4, 8'hA4, 1'b0, 6);

    wait_until(3);  reset = 1'b0;
    wait_until(9);  reset = 1'b1;
    wait_until(R);
    reset = 1'b0; bus.data_in = 32'h1234ABCD; bus.data_valid = 1'b1;
    wait_until(R + 1);  bus.data_valid = 1'b0;

    wait_until(R + 17); bus.half_sel = 1'b1;

    wait_until(R + 33);
    bus.data_in = 32'h0000_0005; bus.data_valid = 1'b1;
    bus.half_sel = 1'b0; bus.blank_lz = 1'b1;
    wait_until(R + 34); bus.data_valid = 1'b0;

    wait_until(R + 49); bus.data_in = 32'h0; bus.data_valid = 1'b1;
    wait_until(R + 50); bus.data_valid = 1'b0;

    wait_until(R + 65);
    bus.data_in = 32'h0000_FFFF; bus.data_valid = 1'b1; bus.blank_lz = 1'b0;
    wait_until(R + 66); bus.data_valid = 1'b0;

    wait_until(R + 69); bus.data_in = 32'h0000_1111; bus.data_valid = 1'b1;
    wait_until(R + 70); bus.data_valid = 1'b0;

    // Strobe held across the slot-end edge R+76 of slot 18.
    wait_until(R + 75); bus.data_in = 32'h0000_2222; bus.data_valid = 1'b1;
    wait_until(R + 76); bus.data_valid = 1'b0;

    wait_until(R + 4 + 4*(20 + NF) + 2);
    done = 1'b1;

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover pending=%0d required=0", q.size());
    end
    checks++;
    if (multi_low != 0) begin
      failures++;
      $display("FAIL multi_anode_low count=%0d required=0", multi_low);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
